dcache_ctrl: RTL and testbench

Control FSM for the direct-mapped, word-line, write-through data cache; sits between the CPU load/store port and the memory bus. It drives the cache tag/data store (idx/tag/we/re/wdata in, rdata/hit out, one-cycle synchronous read). On read misses it fetches from memory and fills the store. Writes always go through to memory; uncached accesses bypass the store.

---
 rtl/dcache_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Control FSM for a direct-mapped, one-word-per-line, write-through data cache.
// Sequences CPU requests through a tag/data store lookup and the memory bus.
module dcache_ctrl #(
  parameter int NUM_LINES  = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_BITS  = $clog2(NUM_LINES),
  localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [3:0]            cpu_wstrb,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  cpu_cacheable,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  st_flush,
  output logic [IDX_BITS-1:0]   st_idx,
  output logic [TAG_BITS-1:0]   st_tag,
  output logic                  st_re,
  output logic                  st_we,
  output logic [DATA_WIDTH-1:0] st_wdata,
  input  logic [DATA_WIDTH-1:0] st_rdata,
  input  logic                  st_hit
);

  localparam int LANE_W = DATA_WIDTH / 4;
  localparam int WORD_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    accept;
  logic [WORD_W-1:0]       req_word;
  logic [3:0]              req_wstrb;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    req_cacheable;
  logic [IDX_BITS-1:0]     req_idx;
  logic [TAG_BITS-1:0]     req_tag;
  logic                    unused_addr_bits;

  // Replace strobed byte lanes of the stored word with the new store data.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [3:0]            strb
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[b*LANE_W +: LANE_W] = new_word[b*LANE_W +: LANE_W];
    end
    return merged;
  endfunction

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign req_idx   = req_word[IDX_BITS-1:0];
  assign req_tag   = req_word[WORD_W-1:IDX_BITS];
  assign mem_addr  = {req_word, 2'b00};
  assign mem_wdata = req_wdata;
  assign st_flush  = flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      req_word      <= '0;
      req_wstrb     <= '0;
      req_wdata     <= '0;
      req_cacheable <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_word      <= cpu_addr[ADDR_WIDTH-1:2];
        req_wstrb     <= cpu_wstrb;
        req_wdata     <= cpu_wdata;
        req_cacheable <= cpu_cacheable;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    st_idx    = req_idx;
    st_tag    = req_tag;
    st_re     = 1'b0;
    st_we     = 1'b0;
    st_wdata  = '0;
    case (state)
      IDLE: begin
        if (cpu_valid) begin
          accept = 1'b1;
          if (cpu_cacheable) begin
            // Start the store read now so hit/data are ready in LOOKUP.
            st_re     = 1'b1;
            st_idx    = cpu_addr[IDX_BITS+1:2];
            st_tag    = cpu_addr[ADDR_WIDTH-1:IDX_BITS+2];
            state_nxt = LOOKUP;
          end else if (cpu_wstrb == 4'b0000) begin
            state_nxt = MEM_RD;
          end else begin
            state_nxt = MEM_WR;
          end
        end
      end
      LOOKUP: begin
        if (req_wstrb == 4'b0000) begin
          if (st_hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = st_rdata;
            state_nxt = IDLE;
          end else begin
            state_nxt = MEM_RD;
          end
        end else begin
          // Write-through, no allocate: only refresh the store on a hit.
          st_we     = st_hit;
          st_wdata  = byte_merge(st_rdata, req_wdata, req_wstrb);
          state_nxt = MEM_WR;
        end
      end
      MEM_RD: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          cpu_ready = 1'b1;
          cpu_rdata = mem_rdata;
          st_we     = req_cacheable;
          st_wdata  = mem_rdata;
          state_nxt = IDLE;
        end
      end
      MEM_WR: begin
        mem_valid = 1'b1;
        mem_wstrb = req_wstrb;
        if (mem_ready) begin
          cpu_ready = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: models the tag/data store and memory, and checks every
// request against a transaction-level cache/memory reference.
module tb_dcache_ctrl;

  localparam int NL = 512;
  localparam int TB = 21;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [31:0]   cpu_addr;
  logic [3:0]    cpu_wstrb;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_cacheable;
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          st_flush;
  logic [8:0]    st_idx;
  logic [TB-1:0] st_tag;
  logic          st_re;
  logic          st_we;
  logic [31:0]   st_wdata;
  logic [31:0]   st_rdata;
  logic          st_hit;

  int n_checks = 0;
  int n_errors = 0;

  dcache_ctrl #(.NUM_LINES(NL), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_cacheable(cpu_cacheable),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .st_flush(st_flush), .st_idx(st_idx), .st_tag(st_tag), .st_re(st_re),
    .st_we(st_we), .st_wdata(st_wdata), .st_rdata(st_rdata), .st_hit(st_hit)
  );

  always #5 clk = ~clk;

  // Tag/data store: synchronous read, flush wins over a same-cycle write.
  bit          s_valid [NL];
  bit [TB-1:0] s_tag   [NL];
  bit [31:0]   s_data  [NL];

  always @(posedge clk) begin
    if (st_re) begin
      st_rdata <= s_data[st_idx];
      st_hit   <= s_valid[st_idx] && (s_tag[st_idx] == st_tag);
    end
    if (st_flush) begin
      for (int i = 0; i < NL; i++) s_valid[i] <= 1'b0;
    end else if (st_we) begin
      s_valid[st_idx] <= 1'b1;
      s_tag[st_idx]   <= st_tag;
      s_data[st_idx]  <= st_wdata;
    end
  end

  // Reference: memory contents by word address, cached tag by line index.
  logic [31:0]   ref_mem  [logic [31:0]];
  logic [TB-1:0] ref_line [int unsigned];

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        input bit cach, input bit fl);
    logic [31:0]   wa, old, exp_wed, exp_rd;
    int unsigned   idx;
    logic [TB-1:0] tag;
    bit            is_rd, exp_hit, exp_mem, exp_we, got_ready;
    int            cyc, dly, rcyc, n_re, n_we, n_mem;
    logic [8:0]    we_idx;
    logic [TB-1:0] we_tag;
    logic [31:0]   we_data, m_addr, m_wdata, rdata;
    logic [3:0]    m_strb;

    wa      = addr >> 2;
    idx     = wa % NL;
    tag     = TB'(wa / NL);
    old     = mem_rd(wa);
    is_rd   = (strb == 4'b0000);
    exp_hit = cach && ref_line.exists(idx) && (ref_line[idx] == tag);
    exp_mem = !(is_rd && exp_hit);
    exp_we  = cach && (is_rd ? !exp_hit : exp_hit);
    exp_wed = is_rd ? old : merge(old, wd, strb);
    exp_rd  = is_rd ? old : 32'h0;

    n_re = 0; n_we = 0; n_mem = 0; rcyc = -1; got_ready = 0;
    we_idx = '0; we_tag = '0; we_data = '0; m_addr = '0; m_wdata = '0; m_strb = '0; rdata = '0;

    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = addr; cpu_wstrb = strb; cpu_wdata = wd;
    cpu_cacheable = cach; flush = fl;
    cyc = 0;
    dly = int'($urandom_range(0, 3));
    while (!got_ready && cyc < 40) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_valid) begin
        if (dly == 0) begin
          mem_ready = 1'b1;
          if (mem_wstrb == 4'b0000) mem_rdata = mem_rd(mem_addr >> 2);
        end else begin
          dly--;
        end
      end
      #1;
      if (st_re) n_re++;
      if (st_we) begin
        n_we++; we_idx = st_idx; we_tag = st_tag; we_data = st_wdata;
      end
      if (mem_valid && mem_ready) begin
        n_mem++; m_addr = mem_addr; m_strb = mem_wstrb; m_wdata = mem_wdata;
      end
      if (cpu_ready) begin
        got_ready = 1; rdata = cpu_rdata; rcyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    cpu_valid = 1'b0; mem_ready = 1'b0; flush = 1'b0;
    #1;
    check("done", 64'(got_ready), 64'd1);
    check("ready_pulse", 64'(cpu_ready), 64'd0);
    check("mem_valid_drop", 64'(mem_valid), 64'd0);
    check("rdata", 64'(rdata), 64'(exp_rd));
    check("mem_ops", 64'(n_mem), 64'(exp_mem));
    if (exp_mem) begin
      check("mem_addr", 64'(m_addr), 64'(addr & 32'hFFFF_FFFC));
      check("mem_wstrb", 64'(m_strb), 64'(strb));
      if (!is_rd) check("mem_wdata", 64'(m_wdata), 64'(wd));
    end
    check("st_re_cnt", 64'(n_re), 64'(cach));
    check("st_we_cnt", 64'(n_we), 64'(exp_we));
    if (exp_we) begin
      check("st_we_idx", 64'(we_idx), 64'(idx));
      check("st_we_tag", 64'(we_tag), 64'(tag));
      check("st_wdata", 64'(we_data), 64'(exp_wed));
    end
    if (is_rd && exp_hit) check("hit_latency", 64'(rcyc), 64'd1);

    if (!is_rd) ref_mem[wa] = merge(old, wd, strb);
    if (fl) ref_line.delete();
    else if (cach && is_rd && !exp_hit) ref_line[idx] = tag;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("st_flush", 64'(st_flush), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    ref_line.delete();
  endtask

  task automatic reset_mid_read(input logic [31:0] addr);
    int cyc;
    bit saw_ready;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = addr; cpu_wstrb = 4'b0000; cpu_cacheable = 1'b1; mem_ready = 1'b0;
    cyc = 0;
    while (!mem_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_mem", 64'(mem_valid), 64'd1);
    @(negedge clk);
    resetn = 1'b0; cpu_valid = 1'b0;
    #1;
    check("rst_no_ready", 64'(cpu_ready), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    saw_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (cpu_ready || mem_valid) saw_ready = 1;
    end
    check("rst_idle_after", 64'(saw_ready), 64'd0);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  s;
    bit          c;

    resetn = 1'b0; flush = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wstrb = '0;
    cpu_wdata = '0; cpu_cacheable = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    check("rst_mem_valid0", 64'(mem_valid), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_st_we", 64'(st_we), 64'd0);
    check("rst_st_re", 64'(st_re), 64'd0);
    resetn = 1'b1;

    ref_mem[32'h0000_1000 >> 2] = 32'hDEAD_BEEF;
    do_req(32'h0000_1000, 4'b0000, 32'h0, 1'b1, 1'b0);
    do_req(32'h0000_1000, 4'b0000, 32'h0, 1'b1, 1'b0);
    do_req(32'h0000_1000, 4'b0011, 32'h0000_1234, 1'b1, 1'b0);
    do_req(32'h0000_1000, 4'b0000, 32'h0, 1'b1, 1'b0);
    check("write_hit_value", 64'(mem_rd(32'h0000_1000 >> 2)), 64'h0000_0000_DEAD_1234);
    do_req(32'h0000_2004, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0);
    do_req(32'h0000_2004, 4'b0000, 32'h0, 1'b1, 1'b0);
    do_req(32'h0000_1800, 4'b0000, 32'h0, 1'b1, 1'b0);
    do_req(32'h0000_1000, 4'b0000, 32'h0, 1'b1, 1'b0);
    do_req(32'h1000_0000, 4'b0000, 32'h0, 1'b0, 1'b0);
    do_req(32'h1000_0008, 4'b1100, 32'hAB12_0000, 1'b0, 1'b0);
    do_req(32'h0000_3000, 4'b0000, 32'h0, 1'b1, 1'b0);
    do_flush();
    do_req(32'h0000_3000, 4'b0000, 32'h0, 1'b1, 1'b0);
    do_req(32'h0000_4000, 4'b0000, 32'h0, 1'b1, 1'b1);
    do_req(32'h0000_4000, 4'b0000, 32'h0, 1'b1, 1'b0);
    reset_mid_read(32'h0000_5000);
    do_req(32'h0000_4000, 4'b0000, 32'h0, 1'b1, 1'b0);

    for (int n = 0; n < 250; n++) begin
      c  = ($urandom_range(0, 7) != 0);
      a  = c ? ((32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 7)) << 2))
             : (32'h1000_0000 | (32'($urandom_range(0, 15)) << 2));
      a  = a | 32'($urandom_range(0, 3));
      s  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      wd = $urandom;
      do_req(a, s, wd, c, 1'b0);
      if ($urandom_range(0, 30) == 0) do_flush();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
